mips_register_file: RTL

- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Consumes the destination-register index produced by the destination-register select mux (rt for I-type, rd for R-type) together with the write-back data and RegWrite.
- Supplies the rs/rt operands to the ALU and store path.
- Register $0 is hardwired to zero.
- Provides a write-trace port for benches.

---
 rtl/mips_register_file.sv | 70 +++++++
 1 files changed

// File: rtl/mips_register_file.sv
// mips_register_file: 32 x 32 GPR file for the single-cycle MIPS datapath.
// $0 reads as zero and is never written; two async read ports, one write port.
// Ports: clk, reset (async, active-high), read_reg1/read_reg2 -> read_data1/2,
//   write_reg/write_data/reg_write (commit on rising clk), trace outputs
//   last_wr_reg/last_wr_data/wr_count (count of committed writes, wraps).
// Option: define WRITE_BYPASS_EN to forward write_data to a matching read port.
module mips_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [ADDR_W-1:0] last_wr_reg,
  output logic [DATA_W-1:0] last_wr_data,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              we;

  // reg_write is tested first so an unknown write_reg cannot
  // enable a commit while the port is idle.
  assign we = reg_write && (write_reg != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      last_wr_reg  <= '0;
      last_wr_data <= '0;
      wr_count     <= '0;
    end else if (we) begin
      mem[write_reg] <= write_data;
      last_wr_reg    <= write_reg;
      last_wr_data   <= write_data;
      wr_count       <= wr_count + 16'd1;
    end
  end

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read_reg1 != '0) begin
      read_data1 = mem[read_reg1];
    end
    if (read_reg2 != '0) begin
      read_data2 = mem[read_reg2];
    end
`ifdef WRITE_BYPASS_EN
    // we already excludes $0, so register zero is never forwarded.
    if (we && (write_reg == read_reg1)) begin
      read_data1 = write_data;
    end
    if (we && (write_reg == read_reg2)) begin
      read_data2 = write_data;
    end
`endif
  end

endmodule
